// File: rtl/bus_lock_queue.sv
// Bus lock queue: DEPTH-entry FIFO in front of a held-value latch on outBus.
// Define BUS_LOCK_QUEUE_STATS_EN to add the saturating drop_count output.
module bus_lock_queue #(
   parameter int BUS_WIDTH        = 8,
   parameter int DEPTH            = 4,
   parameter int OVERWRITE_OLDEST = 0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     trigger,
   input  logic [BUS_WIDTH-1:0]     inBus,
   input  logic                     out_ready,
   input  logic                     clear_overflow,
   output logic [BUS_WIDTH-1:0]     outBus,
   output logic                     out_valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
`ifdef BUS_LOCK_QUEUE_STATS_EN
   ,
   output logic [15:0]              drop_count
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

   logic [BUS_WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW:0]          count_q, count_d;
   logic [BUS_WIDTH-1:0] held_q, held_d;
   logic                 overflow_q, overflow_d;
   logic                 is_full, is_empty, do_pop, do_write, ovf_event;
`ifdef BUS_LOCK_QUEUE_STATS_EN
   logic [15:0]          drop_count_q, drop_count_d;
`endif

   always_comb begin
      is_full    = (count_q == DEPTH_C);
      is_empty   = (count_q == '0);
      do_pop     = !is_empty && out_ready;
      ovf_event  = trigger && is_full && !do_pop;
      do_write   = trigger && (!ovf_event || (OVERWRITE_OLDEST != 0));

      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      held_d     = held_q;
      overflow_d = overflow_q;

      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         held_d   = mem_q[rd_ptr_q];
      end
      if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
      // Overwrite discards the head by advancing rd_ptr without touching held_q.
      if (ovf_event && (OVERWRITE_OLDEST != 0)) rd_ptr_d = rd_ptr_q + 1'b1;

      if (do_write && !do_pop && !ovf_event) count_d = count_q + 1'b1;
      else if (do_pop && !do_write)          count_d = count_q - 1'b1;

      if (ovf_event)           overflow_d = 1'b1;
      else if (clear_overflow) overflow_d = 1'b0;
   end

`ifdef BUS_LOCK_QUEUE_STATS_EN
   always_comb begin
      drop_count_d = drop_count_q;
      if (clear_overflow)                         drop_count_d = ovf_event ? 16'd1 : 16'd0;
      else if (ovf_event && drop_count_q != '1)   drop_count_d = drop_count_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) drop_count_q <= '0;
      else       drop_count_q <= drop_count_d;
   end

   assign drop_count = drop_count_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         held_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         held_q     <= held_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && do_write) mem_q[wr_ptr_q] <= inBus;
   end

   assign outBus    = is_empty ? held_q : mem_q[rd_ptr_q];
   assign out_valid = !is_empty;
   assign full      = is_full;
   assign count     = count_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_bus_lock_queue.sv
// Bench for bus_lock_queue: drop (dut0) and overwrite (dut1) variants share stimulus,
// checked against a queue-based reference model; honours BUS_LOCK_QUEUE_STATS_EN.
module tb_bus_lock_queue;

   localparam int DEPTH = 4;

   logic       clk;
   logic       reset, trigger, out_ready, clear_overflow;
   logic [7:0] inBus;

   logic [7:0] ob0, ob1;
   logic       ov0, ov1, fu0, fu1, of0, of1;
   logic [2:0] cn0, cn1;
`ifdef BUS_LOCK_QUEUE_STATS_EN
   logic [15:0] dc0, dc1;
   localparam int VW = 30;
`else
   localparam int VW = 14;
`endif
   logic [VW-1:0] dv [2];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // reference model state
   logic [7:0]  mq [2][$];
   logic [7:0]  held_m [2];
   logic        ovf_m [2];
   logic [15:0] dc_m [2];

   bus_lock_queue #(.BUS_WIDTH(8), .DEPTH(DEPTH), .OVERWRITE_OLDEST(0)) dut0 (
      .clk(clk), .reset(reset), .trigger(trigger), .inBus(inBus),
      .out_ready(out_ready), .clear_overflow(clear_overflow),
      .outBus(ob0), .out_valid(ov0), .full(fu0), .count(cn0), .overflow(of0)
`ifdef BUS_LOCK_QUEUE_STATS_EN
      , .drop_count(dc0)
`endif
   );

   bus_lock_queue #(.BUS_WIDTH(8), .DEPTH(DEPTH), .OVERWRITE_OLDEST(1)) dut1 (
      .clk(clk), .reset(reset), .trigger(trigger), .inBus(inBus),
      .out_ready(out_ready), .clear_overflow(clear_overflow),
      .outBus(ob1), .out_valid(ov1), .full(fu1), .count(cn1), .overflow(of1)
`ifdef BUS_LOCK_QUEUE_STATS_EN
      , .drop_count(dc1)
`endif
   );

`ifdef BUS_LOCK_QUEUE_STATS_EN
   assign dv[0] = {ob0, ov0, fu0, cn0, of0, dc0};
   assign dv[1] = {ob1, ov1, fu1, cn1, of1, dc1};
`else
   assign dv[0] = {ob0, ov0, fu0, cn0, of0};
   assign dv[1] = {ob1, ov1, fu1, cn1, of1};
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [VW-1:0] exp_vec(int k);
      int         n;
      logic [7:0] o;
      logic       v, f;
      logic [2:0] c;
      n = mq[k].size();
      o = (n > 0) ? mq[k][0] : held_m[k];
      v = (n > 0);
      f = (n == DEPTH);
      c = 3'(n);
`ifdef BUS_LOCK_QUEUE_STATS_EN
      return {o, v, f, c, ovf_m[k], dc_m[k]};
`else
      return {o, v, f, c, ovf_m[k]};
`endif
   endfunction

   // Model: pop first, then push; a push into a still-full queue is an overflow event.
   task automatic model_step();
      int         n;
      logic       popv, ev;
      logic [7:0] junk;
      for (int k = 0; k < 2; k++) begin
         n = mq[k].size();
         if (reset) begin
            mq[k].delete();
            held_m[k] = '0;
            ovf_m[k]  = 1'b0;
            dc_m[k]   = '0;
         end else begin
            popv = (n > 0) && out_ready;
            ev   = trigger && (n == DEPTH) && !popv;
            if (popv) held_m[k] = mq[k].pop_front();
            if (trigger) begin
               if (!ev) mq[k].push_back(inBus);
               else if (k == 1) begin
                  junk = mq[k].pop_front();
                  mq[k].push_back(inBus);
               end
            end
            if (ev)                  ovf_m[k] = 1'b1;
            else if (clear_overflow) ovf_m[k] = 1'b0;
            if (clear_overflow)                  dc_m[k] = ev ? 16'd1 : 16'd0;
            else if (ev && dc_m[k] != 16'hFFFF)  dc_m[k] = dc_m[k] + 16'd1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
   endtask

   task automatic drive_idle();
      reset = 0; trigger = 0; out_ready = 0; clear_overflow = 0; inBus = '0;
   endtask

   task automatic do_reset();
      drive_idle();
      reset = 1;
      tick();
      reset = 0;
   endtask

   task automatic fill4();
      logic [7:0] w [4];
      w = '{8'h11, 8'h22, 8'h33, 8'h44};
      out_ready = 0;
      for (int i = 0; i < 4; i++) begin
         trigger = 1; inBus = w[i];
         tick();
      end
      trigger = 0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 3; i++) tick();
      n_checks++;
      if ({ob0, ov0, cn0, fu0, of0} !== 14'd0) begin
         n_fail++;
         $display("FAIL reset_state got=%h exp=0", {ob0, ov0, cn0, fu0, of0});
      end
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (dv[k] !== exp_vec(k)) begin
            n_fail++;
            $display("FAIL reset_model dut%0d got=%h exp=%h", k, dv[k], exp_vec(k));
         end
      end
   endtask

   task automatic test_fill_drain();
      logic [7:0] s [4];
      s = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_reset();
      fill4();
      n_checks++;
      if (cn0 !== 3'd4 || fu0 !== 1'b1 || ob0 !== 8'h11) begin
         n_fail++;
         $display("FAIL fill_full got cnt=%0d full=%b out=%h exp cnt=4 full=1 out=11", cn0, fu0, ob0);
      end
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (ob0 !== s[i]) begin
            n_fail++;
            $display("FAIL drain_seq[%0d] got=%h exp=%h", i, ob0, s[i]);
         end
         tick();
      end
      out_ready = 0;
      n_checks++;
      if (cn0 !== 3'd0 || ov0 !== 1'b0 || ob0 !== 8'h44) begin
         n_fail++;
         $display("FAIL drain_hold got cnt=%0d valid=%b out=%h exp cnt=0 valid=0 out=44", cn0, ov0, ob0);
      end
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (dv[k] !== exp_vec(k)) begin
            n_fail++;
            $display("FAIL drain_model dut%0d got=%h exp=%h", k, dv[k], exp_vec(k));
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] s0 [4];
      logic [7:0] s1 [4];
      s0 = '{8'h11, 8'h22, 8'h33, 8'h44};
      s1 = '{8'h22, 8'h33, 8'h44, 8'h55};
      do_reset();
      fill4();
      trigger = 1; inBus = 8'h55;
      tick();
      trigger = 0;
      n_checks++;
      if (of0 !== 1'b1 || of1 !== 1'b1 || cn0 !== 3'd4 || cn1 !== 3'd4) begin
         n_fail++;
         $display("FAIL overflow_flag got of0=%b of1=%b cnt0=%0d cnt1=%0d exp 1 1 4 4", of0, of1, cn0, cn1);
      end
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (ob0 !== s0[i] || ob1 !== s1[i]) begin
            n_fail++;
            $display("FAIL overflow_drain[%0d] got %h/%h exp %h/%h", i, ob0, ob1, s0[i], s1[i]);
         end
         tick();
      end
      out_ready = 0;
      clear_overflow = 1;
      tick();
      clear_overflow = 0;
      n_checks++;
      if (of0 !== 1'b0 || of1 !== 1'b0) begin
         n_fail++;
         $display("FAIL overflow_clear got of0=%b of1=%b exp 0 0", of0, of1);
      end
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (dv[k] !== exp_vec(k)) begin
            n_fail++;
            $display("FAIL overflow_model dut%0d got=%h exp=%h", k, dv[k], exp_vec(k));
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] p [6];
      p = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA0, 8'hA1};
      do_reset();
      fill4();
      trigger = 1; out_ready = 1;
      for (int i = 0; i < 6; i++) begin
         inBus = 8'hA0 + 8'(i);
         n_checks++;
         if (ob0 !== p[i] || ob1 !== p[i]) begin
            n_fail++;
            $display("FAIL b2b_pop[%0d] got %h/%h exp %h", i, ob0, ob1, p[i]);
         end
         tick();
         n_checks++;
         if (cn0 !== 3'd4 || cn1 !== 3'd4 || of0 !== 1'b0 || of1 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_level[%0d] got cnt=%0d/%0d ovf=%b/%b exp 4/4 0/0", i, cn0, cn1, of0, of1);
         end
      end
      drive_idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         trigger = 1; inBus = 8'hC0 + 8'(i);
         tick();
      end
      reset = 1; trigger = 1; inBus = 8'hEE;
      tick();
      drive_idle();
      n_checks++;
      if (cn0 !== 3'd0 || ob0 !== 8'h00 || ov0 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid got cnt=%0d out=%h valid=%b exp 0 00 0", cn0, ob0, ov0);
      end
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if (dv[k] !== exp_vec(k)) begin
            n_fail++;
            $display("FAIL reset_mid_model dut%0d got=%h exp=%h", k, dv[k], exp_vec(k));
         end
      end
   endtask

`ifdef BUS_LOCK_QUEUE_STATS_EN
   task automatic test_stats();
      do_reset();
      fill4();
      for (int i = 0; i < 3; i++) begin
         trigger = 1; inBus = 8'h70 + 8'(i);
         tick();
      end
      trigger = 0;
      n_checks++;
      if (dc0 !== 16'd3 || dc1 !== 16'd3) begin
         n_fail++;
         $display("FAIL stats_count got %0d/%0d exp 3/3", dc0, dc1);
      end
      trigger = 1; clear_overflow = 1;
      tick();
      drive_idle();
      n_checks++;
      if (dc0 !== 16'd1 || dc1 !== 16'd1 || of0 !== 1'b1) begin
         n_fail++;
         $display("FAIL stats_clear_event got %0d/%0d ovf=%b exp 1/1 1", dc0, dc1, of0);
      end
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 500; i++) begin
         reset          = ($urandom_range(0, 99) < 2);
         trigger        = ($urandom_range(0, 99) < 60);
         out_ready      = ($urandom_range(0, 99) < 45);
         clear_overflow = ($urandom_range(0, 99) < 8);
         inBus          = 8'($urandom);
         tick();
         for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (dv[k] !== exp_vec(k)) begin
               n_fail++;
               $display("FAIL random_model dut%0d cyc=%0d got=%h exp=%h", k, cyc, dv[k], exp_vec(k));
            end
         end
      end
      drive_idle();
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_fill_drain();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
`ifdef BUS_LOCK_QUEUE_STATS_EN
      test_stats();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
